// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: opcodes, FSM states,
// aluOp values and datapath mux selects.
package riscv_ctrl_pkg;

    // Opcode field IR[6:0]
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // Main control FSM states
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_FAULT    = 4'd9
    } state_t;

    // aluOp as consumed by alu_control
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REGA  = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

    // States that hold a memory request open until mem_ready
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory state has waited on mem_ready and flags a timeout when
// the limit is reached with the memory still not ready.
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_active,
    input  logic i_ready,
    output logic o_timeout
);
    localparam int W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    logic [W-1:0] r_count;

    // Clear on any state change; count stalled cycles only while a request is open
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_active && !i_ready)
            r_count <= r_count + 1'b1;
    end

    // A ready in the limit cycle still completes normally; limit 0 disables timeout
    always_comb begin
        o_timeout = 1'b0;
        if (MEM_WAIT_MAX != 0)
            o_timeout = i_active && !i_ready && (r_count == W'(MEM_WAIT_MAX));
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RISC-V datapath: sequences fetch, decode,
// memory, execute and writeback; flags faults and counts retired instructions.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       aluOp,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_timeout;
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;

    mem_wait_timer #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX)
    ) u_timer (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_clear  (w_state_next != r_state),
        .i_active (is_mem_state(r_state)),
        .i_ready  (mem_ready),
        .o_timeout(w_timeout)
    );

    // State register; reset aborts any in-flight instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_FETCH;
        else
            r_state <= w_state_next;
    end

    // Next-state logic; mem_ready takes priority over a timeout in the same cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_state_next = S_DECODE;
                else if (w_timeout) w_state_next = S_FAULT;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_RTYPE:     w_state_next = S_EXECR;
                    OP_BEQ:       w_state_next = S_BEQ;
                    default:      w_state_next = S_FAULT;
                endcase
            end
            S_MEMADR:   w_state_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready)      w_state_next = S_MEMWB;
                else if (w_timeout) w_state_next = S_FAULT;
            end
            S_MEMWB:    w_state_next = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready)      w_state_next = S_FETCH;
                else if (w_timeout) w_state_next = S_FAULT;
            end
            S_EXECR:    w_state_next = S_ALUWB;
            S_ALUWB:    w_state_next = S_FETCH;
            S_BEQ:      w_state_next = S_FETCH;
            S_FAULT:    w_state_next = S_FAULT;
            default:    w_state_next = S_FAULT;
        endcase
    end

    // Moore output decode; only the FETCH/BEQ write enables see live inputs
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REGB;
        aluOp      = ALUOP_ADD;
        fault      = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_REGA;
                aluOp     = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRCA_REGA;
                aluOp     = ALUOP_BRANCH;
                pc_write  = zero;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BEQ) ||
                      ((r_state == S_MEMWRITE) && mem_ready);

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_retired <= '0;
        else if (w_retire)
            r_retired <= r_retired + CNT_W'(1);
    end

    assign retired = r_retired;

endmodule
